// File: rtl/sap1_out_tx.sv
// rtl/sap1_out_tx.sv - SAP-1 output port with UART-style serial transmitter
//
// Captures the W-bus into the parallel output register on an accepted
// output-load strobe, then shifts the same byte out LSB first as a
// start / 8 data / [parity] / stop frame, each bit CLKS_PER_BIT cycles.
//
// Optional feature macro: OUT_TX_PARITY_EN
//   defined   -> even-parity bit between data bit 7 and stop (11-bit frame)
//   undefined -> 10-bit frame, no parity state or logic
//
// Ports:
//   clk      system clock, rising edge
//   rst      asynchronous active-high reset
//   load     output-load strobe (Lo)
//   bus      8-bit W-bus value
//   out      8-bit parallel display register
//   tx       serial line, idles high
//   busy     frame in progress, loads rejected
//   done     one-cycle pulse after the stop bit
//   overrun  sticky: a load was dropped while busy

module sap1_out_tx #(
  parameter int CLKS_PER_BIT = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [7:0] bus,
  output logic [7:0] out,
  output logic       tx,
  output logic       busy,
  output logic       done,
  output logic       overrun
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);

`ifdef OUT_TX_PARITY_EN
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } state_t;
`else
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_DATA  = 3'd2,
    ST_STOP  = 3'd4
  } state_t;
`endif

  state_t        r_state;
  state_t        w_state_next;
  logic [CW-1:0] r_cnt;
  logic [2:0]    r_bit;
  logic [7:0]    r_shift;
  logic [7:0]    r_out;
  logic          r_done;
  logic          r_overrun;
  logic          w_last;
  logic          w_tx;

  // Final cycle of the current bit period.
  assign w_last = (r_cnt == CNT_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_tx         = 1'b1;
    case (r_state)
      ST_IDLE: begin
        if (load) begin
          w_state_next = ST_START;
        end
      end
      ST_START: begin
        w_tx = 1'b0;
        if (w_last) begin
          w_state_next = ST_DATA;
        end
      end
      ST_DATA: begin
        w_tx = r_shift[r_bit];
        if (w_last && (r_bit == 3'd7)) begin
`ifdef OUT_TX_PARITY_EN
          w_state_next = ST_PARITY;
`else
          w_state_next = ST_STOP;
`endif
        end
      end
`ifdef OUT_TX_PARITY_EN
      ST_PARITY: begin
        w_tx = ^r_shift;
        if (w_last) begin
          w_state_next = ST_STOP;
        end
      end
`endif
      ST_STOP: begin
        if (w_last) begin
          w_state_next = ST_IDLE;
        end
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  // Datapath: baud counter, bit index, shift/output registers, flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt     <= '0;
      r_bit     <= 3'd0;
      r_shift   <= 8'h00;
      r_out     <= 8'h00;
      r_done    <= 1'b0;
      r_overrun <= 1'b0;
    end else begin
      // Counter restarts on every bit boundary, which includes every
      // state transition out of a timed state.
      if ((r_state == ST_IDLE) || w_last) begin
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end

      if (r_state == ST_START) begin
        r_bit <= 3'd0;
      end else if ((r_state == ST_DATA) && w_last && (r_bit != 3'd7)) begin
        r_bit <= r_bit + 3'd1;
      end

      if (load) begin
        if (r_state == ST_IDLE) begin
          r_out     <= bus;
          r_shift   <= bus;
          r_overrun <= 1'b0;
        end else begin
          r_overrun <= 1'b1;
        end
      end

      r_done <= (r_state == ST_STOP) && w_last;
    end
  end

  assign out     = r_out;
  assign tx      = w_tx;
  assign busy    = (r_state != ST_IDLE);
  assign done    = r_done;
  assign overrun = r_overrun;

endmodule

// File: tb/tb_sap1_out_tx.sv
// tb/tb_sap1_out_tx.sv - self-checking bench for sap1_out_tx

module tb_sap1_out_tx;

  localparam int C = 4;
`ifdef OUT_TX_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif
  localparam int FL = NB * C;

  logic       clk = 1'b0;
  logic       rst;
  logic       load;
  logic [7:0] bus;
  wire  [7:0] out;
  wire        tx;
  wire        busy;
  wire        done;
  wire        overrun;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  sap1_out_tx #(.CLKS_PER_BIT(C)) dut (
    .clk    (clk),
    .rst    (rst),
    .load   (load),
    .bus    (bus),
    .out    (out),
    .tx     (tx),
    .busy   (busy),
    .done   (done),
    .overrun(overrun)
  );

  // Expected line level k cycles after the accepting edge.
  function automatic logic model_tx(input logic [7:0] b, input int k);
    logic [10:0] frame;
    frame    = '1;
    frame[0] = 1'b0;
    for (int i = 0; i < 8; i++) frame[i+1] = b[i];
    if (NB == 11) frame[9] = ^b;
    if (k < 0 || k >= FL) return 1'b1;
    return frame[k / C];
  endfunction

  // Present one-cycle load; returns at the negedge after the accepting edge.
  task automatic accept(input logic [7:0] b);
    @(negedge clk);
    load = 1'b1;
    bus  = b;
    @(negedge clk);
    load = 1'b0;
    bus  = 8'($urandom);
  endtask

  task automatic test_reset;
    rst  = 1'b1;
    load = 1'b0;
    bus  = 8'h00;
    repeat (2) @(negedge clk);
    checks++; if (out !== 8'h00)   begin errors++; $display("FAIL reset_out got %h exp 00", out); end
    checks++; if (tx !== 1'b1)     begin errors++; $display("FAIL reset_tx got %b exp 1", tx); end
    checks++; if (busy !== 1'b0)   begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
    checks++; if (done !== 1'b0)   begin errors++; $display("FAIL reset_done got %b exp 0", done); end
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL reset_overrun got %b exp 0", overrun); end
    rst = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (tx !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL idle_after_reset tx=%b busy=%b exp 1/0", tx, busy); end
  endtask

  task automatic test_frame;
    logic [7:0] bytes [6];
    int busy_cnt;
    int done_cnt;
    bytes[0] = 8'hA5;
    for (int j = 1; j < 6; j++) bytes[j] = 8'($urandom);
    for (int j = 0; j < 6; j++) begin
      accept(bytes[j]);
      busy_cnt = 0;
      done_cnt = 0;
      for (int k = 0; k <= FL; k++) begin
        checks++; if (tx !== model_tx(bytes[j], k)) begin errors++; $display("FAIL frame_tx b=%h k=%0d got %b exp %b", bytes[j], k, tx, model_tx(bytes[j], k)); end
        checks++; if (out !== bytes[j]) begin errors++; $display("FAIL frame_out k=%0d got %h exp %h", k, out, bytes[j]); end
        checks++; if (busy !== (k < FL)) begin errors++; $display("FAIL frame_busy k=%0d got %b exp %b", k, busy, (k < FL)); end
        checks++; if (done !== (k == FL)) begin errors++; $display("FAIL frame_done k=%0d got %b exp %b", k, done, (k == FL)); end
        if (busy === 1'b1) busy_cnt++;
        if (done === 1'b1) done_cnt++;
        if (k < FL) @(negedge clk);
      end
      @(negedge clk);
      checks++; if (done !== 1'b0) begin errors++; $display("FAIL done_width got %b exp 0", done); end
      checks++; if (busy_cnt != FL) begin errors++; $display("FAIL busy_cycles got %0d exp %0d", busy_cnt, FL); end
      checks++; if (done_cnt != 1) begin errors++; $display("FAIL done_pulses got %0d exp 1", done_cnt); end
      checks++; if (out !== bytes[j]) begin errors++; $display("FAIL out_hold got %h exp %h", out, bytes[j]); end
    end
  endtask

  task automatic test_overrun;
    accept(8'h3C);
    for (int k = 0; k <= FL; k++) begin
      checks++; if (tx !== model_tx(8'h3C, k)) begin errors++; $display("FAIL ovr_tx k=%0d got %b exp %b", k, tx, model_tx(8'h3C, k)); end
      checks++; if (out !== 8'h3C) begin errors++; $display("FAIL ovr_out k=%0d got %h exp 3c", k, out); end
      checks++; if (overrun !== (k > 10)) begin errors++; $display("FAIL ovr_flag k=%0d got %b exp %b", k, overrun, (k > 10)); end
      if (k == 10) begin load = 1'b1; bus = 8'hFF; end
      if (k == 11) load = 1'b0;
      if (k < FL) @(negedge clk);
    end
    accept(8'h01);
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL ovr_clear got %b exp 0", overrun); end
    checks++; if (out !== 8'h01) begin errors++; $display("FAIL ovr_next_out got %h exp 01", out); end
    repeat (FL + 1) @(negedge clk);
  endtask

  task automatic test_stop_edge;
    logic [7:0] a;
    logic [7:0] b;
    a = 8'($urandom);
    b = ~a;
    accept(a);
    repeat (FL - 1) @(negedge clk);
    load = 1'b1;
    bus  = b;
    @(negedge clk);
    checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL stop_edge_overrun got %b exp 1", overrun); end
    checks++; if (done !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL stop_edge_done done=%b busy=%b exp 1/0", done, busy); end
    checks++; if (out !== a) begin errors++; $display("FAIL stop_edge_out got %h exp %h", out, a); end
    @(negedge clk);
    load = 1'b0;
    checks++; if (out !== b || busy !== 1'b1 || overrun !== 1'b0) begin errors++; $display("FAIL held_load_accept out=%h busy=%b ovr=%b exp %h/1/0", out, busy, overrun, b); end
    repeat (FL) @(negedge clk);
  endtask

  task automatic test_reset_mid_frame;
    int done_seen;
    accept(8'h81);
    repeat (15) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    checks++; if (tx !== 1'b1)     begin errors++; $display("FAIL async_rst_tx got %b exp 1", tx); end
    checks++; if (busy !== 1'b0)   begin errors++; $display("FAIL async_rst_busy got %b exp 0", busy); end
    checks++; if (out !== 8'h00)   begin errors++; $display("FAIL async_rst_out got %h exp 00", out); end
    checks++; if (overrun !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL async_rst_flags ovr=%b done=%b exp 0/0", overrun, done); end
    done_seen = 0;
    repeat (2) begin @(negedge clk); if (done === 1'b1) done_seen++; end
    rst = 1'b0;
    repeat (FL) begin @(negedge clk); if (done === 1'b1) done_seen++; end
    checks++; if (done_seen != 0) begin errors++; $display("FAIL rst_no_done got %0d exp 0", done_seen); end
    accept(8'h55);
    for (int k = 0; k <= FL; k++) begin
      checks++; if (tx !== model_tx(8'h55, k)) begin errors++; $display("FAIL post_rst_tx k=%0d got %b exp %b", k, tx, model_tx(8'h55, k)); end
      if (k < FL) @(negedge clk);
    end
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL post_rst_done got %b exp 1", done); end
  endtask

  task automatic test_back_to_back;
    accept(8'h12);
    repeat (FL) @(negedge clk);
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL b2b_first_done got %b exp 1", done); end
    load = 1'b1;
    bus  = 8'h34;
    @(negedge clk);
    load = 1'b0;
    checks++; if (out !== 8'h34) begin errors++; $display("FAIL b2b_out got %h exp 34", out); end
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL b2b_overrun got %b exp 0", overrun); end
    for (int k = 0; k <= FL; k++) begin
      checks++; if (tx !== model_tx(8'h34, k) || busy !== (k < FL)) begin errors++; $display("FAIL b2b_frame k=%0d tx=%b busy=%b exp %b/%b", k, tx, busy, model_tx(8'h34, k), (k < FL)); end
      if (k < FL) @(negedge clk);
    end
  endtask

`ifdef OUT_TX_PARITY_EN
  task automatic test_parity;
    logic [7:0] vals [2];
    logic       par  [2];
    vals[0] = 8'h07; par[0] = 1'b1;
    vals[1] = 8'h03; par[1] = 1'b0;
    for (int j = 0; j < 2; j++) begin
      accept(vals[j]);
      repeat (9 * C + C / 2) @(negedge clk);
      checks++; if (tx !== par[j]) begin errors++; $display("FAIL parity_bit b=%h got %b exp %b", vals[j], tx, par[j]); end
      repeat (FL - (9 * C + C / 2)) @(negedge clk);
      checks++; if (done !== 1'b1 || FL != 44) begin errors++; $display("FAIL parity_len done=%b len=%0d exp 1/44", done, FL); end
    end
  endtask
`endif

  initial begin
    test_reset;
    test_frame;
    test_overrun;
    test_stop_edge;
    test_reset_mid_frame;
    test_back_to_back;
`ifdef OUT_TX_PARITY_EN
    test_parity;
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sap1_out_tx.md
# sap1_out_tx

SAP-1 output port with serial transmitter. Captures a byte from the shared 8-bit W-bus under the controller's output-load strobe and holds it as the parallel display value. It then shifts the byte out on a UART-style serial line. It is the bus-reading, outward-facing end of the datapath: the accumulator writes the bus, and this block carries that value off-chip.

## Interface
- CLKS_PER_BIT, default 4: clock cycles per serial bit; must be ≥ 1.
- clk  input  1  system clock; all state changes on rising edge.
- rst  input  1  reset, asynchronous, active-high.
- load  input  1  output-load strobe from the controller (Lo); sampled at the rising edge.
- bus  input  8  W-bus value captured on an accepted load.
- out  output  8  parallel output register (display value).
- tx  output  1  serial line; idles high.
- busy  output  1  a frame is in progress; loads are not accepted.
- done  output  1  one-cycle pulse when a frame's stop bit completes.
- overrun  output  1  sticky flag: a load arrived while busy and was dropped.

## Operation
- FSM states: IDLE, START, DATA, PARITY (only when the macro is defined), STOP.
- IDLE: tx=1, busy=0.
  - On a rising edge with load=1, the load is accepted:
    - out ← bus
    - shift register ← bus
    - overrun ← 0
    - state → START
- START: tx=0 for CLKS_PER_BIT cycles, then → DATA with bit index 0.
- DATA: tx = shift[bit index], LSB first. Each bit is held CLKS_PER_BIT cycles. After bit 7 → PARITY if enabled, else → STOP.
- PARITY: tx = even parity of the frame byte (XOR of its 8 bits), held CLKS_PER_BIT cycles, then → STOP.
- STOP: tx=1 for CLKS_PER_BIT cycles, then → IDLE with done=1 for exactly one cycle.
- Rejected load: load=1 while busy=1 is ignored, and overrun ← 1.
  - out, the shift register and the frame in flight are unaffected.
  - overrun remains set until the next accepted load or rst.
- out changes only on an accepted load. It holds its value indefinitely after the frame ends.
- Baud counter: counts 0..CLKS_PER_BIT-1, resets to 0 on every state transition, width $clog2(CLKS_PER_BIT) (min 1). Bit index: 3 bits, no wrap beyond 7.
- Reset (asynchronous, at any point including mid-frame):
  - state=IDLE, out=8'h00, tx=1, busy=0, done=0, overrun=0
  - counters and shift register cleared
  - The partial frame is abandoned. No completion pulse is produced.

## Timing
- Let N be the edge at which a load is accepted and C = CLKS_PER_BIT.
  - Immediately after edge N: out valid, busy=1, tx=0.
  - Data bit i is driven from edge N+(1+i)·C.
  - Stop bit is driven from edge N+9C (N+10C with parity).
  - At edge N+10C (N+11C with parity): busy=0, done=1, tx=1.
  - At the next edge: done=0.
- Frame length: 10·C cycles (11·C with parity).
- busy and done are registered. done is high in the first IDLE cycle.
- Back-to-back: a load asserted during the cycle done=1 is accepted at the next edge. The minimum inter-frame idle is one cycle.
- load held high across a whole frame is accepted once at the first IDLE edge and again at the first IDLE edge after completion. The overrun flag is set on every busy cycle load is seen.
- Simultaneous load and final STOP edge: busy is still 1 at that edge, so the load is rejected (overrun=1).

## Configuration
- OUT_TX_PARITY_EN
  - Defined: PARITY state compiled in. An even-parity bit is inserted between bit 7 and the stop bit; frame is 11·C cycles.
  - Undefined: no PARITY state or logic; frame is 10·C cycles.
  - All ports are identical in both builds.

## Test plan
- Reset: assert rst mid-simulation → out=00, tx=1, busy=0, done=0, overrun=0 immediately, without waiting for a clock edge.
- Frame 0xA5, C=4, no parity: one-cycle load → out=A5 next cycle. tx sampled mid-bit reads 0,1,0,1,0,0,1,0,1,1. busy high for exactly 40 cycles. done pulses once at cycle 40.
- Overrun: load 0x3C, then load 0xFF at cycle 10 → overrun=1, out stays 3C, serial data is 0x3C. A next accepted load 0x01 clears overrun.
- Reset mid-frame: load 0x81, assert rst at cycle 15 → tx=1, busy=0 at once. No done pulse. A fresh load 0x55 after release transmits correctly.
- Back-to-back: load 0x12 then load 0x34 in the done cycle → second frame's start bit begins one cycle after done, with no overrun. out=34 after the second accept.
- OUT_TX_PARITY_EN defined: load 0x07 → parity bit tx=1 after bit 7, frame 44 cycles. Load 0x03 → parity bit 0.
